// File: rtl/nco_sweep_pkg.sv
// ---------------------------------------------------------------------------
// nco_sweep_pkg
// Shared definitions for the NCO frequency-sweep sequencer.
//   - sweep_state_e      : sequencer state encoding
//   - SETTLE_CYC_DEFAULT : phase_inc-to-output latency of the CORDIC NCO
//                          (1 accumulator + 1 quadrant + 31 CORDIC stages)
//   - cnt_width()        : counter width able to hold n-1, never below 1 bit
// ---------------------------------------------------------------------------
package nco_sweep_pkg;

    localparam int unsigned SETTLE_CYC_DEFAULT = 33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_sweep_if.sv
// ---------------------------------------------------------------------------
// nco_sweep_if
// Control/status bundle between a sweep host and nco_sweep_ctrl.
//   master : host side - drives start/abort/cfg_*, observes status
//   slave  : sequencer side - receives start/abort/cfg_*, drives status
// Signals:
//   start, abort                  request strobes
//   cfg_start_inc, cfg_step_inc   first point and per-point increment
//   cfg_num_points, cfg_dwell     point count and measurement cycles per point
//   phase_inc                     to the NCO phase_inc input
//   busy, meas_valid, point_idx   sweep status
//   done, aborted                 one-cycle completion pulses
// ---------------------------------------------------------------------------
interface nco_sweep_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned IDX_W   = 16,
    parameter int unsigned DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic [PHASE_W-1:0] cfg_start_inc;
    logic [PHASE_W-1:0] cfg_step_inc;
    logic [IDX_W-1:0]   cfg_num_points;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [PHASE_W-1:0] phase_inc;
    logic               busy;
    logic               meas_valid;
    logic [IDX_W-1:0]   point_idx;
    logic               done;
    logic               aborted;

    modport master (
        output start, abort, cfg_start_inc, cfg_step_inc, cfg_num_points, cfg_dwell,
        input  phase_inc, busy, meas_valid, point_idx, done, aborted
    );

    modport slave (
        input  start, abort, cfg_start_inc, cfg_step_inc, cfg_num_points, cfg_dwell,
        output phase_inc, busy, meas_valid, point_idx, done, aborted
    );
endinterface

// File: rtl/nco_sweep_timer.sv
// ---------------------------------------------------------------------------
// nco_sweep_timer
// Loadable down-counter. Counts down once per cycle and parks at zero.
//   clock, reset_n  system clock, asynchronous active-low reset
//   load_i          load strobe (priority over counting)
//   load_val_i      value loaded on load_i
//   zero_o          counter currently equals zero
// ---------------------------------------------------------------------------
module nco_sweep_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl
// Frequency-sweep sequencer for the CORDIC NCO. Steps phase_inc through
// cfg_num_points equally spaced values; at each point waits SETTLE_CYC cycles
// for the NCO pipeline to flush, then holds meas_valid for max(cfg_dwell,1)
// cycles.
//   clock, reset_n  system clock, asynchronous active-low reset
//   bus (slave)     start/abort/cfg_* in; phase_inc, busy, meas_valid,
//                   point_idx, done, aborted out (all registered)
// ---------------------------------------------------------------------------
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned IDX_W      = 16,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic      clock,
    input  logic      reset_n,
    nco_sweep_if.slave bus
);
    localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    sweep_state_e       state_q;
    logic [PHASE_W-1:0] phase_inc_q, phase_inc_d;
    logic [PHASE_W-1:0] step_q;
    logic [IDX_W-1:0]   num_q;
    logic [IDX_W-1:0]   point_idx_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               busy_q, meas_valid_q, done_q, aborted_q;

    logic               abort_ok, start_ok, last_point;
    logic               settle_load, settle_zero;
    logic               dwell_load, dwell_zero;
    logic [DWELL_W-1:0] dwell_load_val;

    // NOTE: every signal in this always_comb gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        abort_ok       = 1'b0;
        start_ok       = 1'b0;
        last_point     = 1'b0;
        settle_load    = 1'b0;
        dwell_load     = 1'b0;
        dwell_load_val = '0;
        phase_inc_d    = phase_inc_q + step_q;

        abort_ok   = (state_q != ST_IDLE) && bus.abort;
        start_ok   = (state_q == ST_IDLE) && bus.start && (bus.cfg_num_points != '0);
        // num_q is non-zero whenever a sweep is running, so this cannot underflow.
        last_point = (point_idx_q == (num_q - IDX_W'(1)));

        settle_load = start_ok ||
                      ((state_q == ST_DWELL) && !abort_ok && dwell_zero && !last_point);
        dwell_load  = (state_q == ST_SETTLE) && !abort_ok && settle_zero;
        // A dwell of 0 still opens a one-cycle window.
        dwell_load_val = (dwell_q == '0) ? '0 : (dwell_q - DWELL_W'(1));
    end

    nco_sweep_timer #(.W(SETTLE_W)) u_settle_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LOAD),
        .zero_o     (settle_zero)
    );

    nco_sweep_timer #(.W(DWELL_W)) u_dwell_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (dwell_load),
        .load_val_i (dwell_load_val),
        .zero_o     (dwell_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_inc_q  <= '0;
            step_q       <= '0;
            num_q        <= '0;
            dwell_q      <= '0;
            point_idx_q  <= '0;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (abort_ok) begin
                // phase_inc and point_idx hold so the NCO stays where it stopped.
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                meas_valid_q <= 1'b0;
                aborted_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (bus.cfg_num_points == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                step_q      <= bus.cfg_step_inc;
                                num_q       <= bus.cfg_num_points;
                                dwell_q     <= bus.cfg_dwell;
                                phase_inc_q <= bus.cfg_start_inc;
                                point_idx_q <= '0;
                                busy_q      <= 1'b1;
                                state_q     <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_zero) begin
                            meas_valid_q <= 1'b1;
                            state_q      <= ST_DWELL;
                        end
                    end
                    ST_DWELL: begin
                        if (dwell_zero) begin
                            meas_valid_q <= 1'b0;
                            if (last_point) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                phase_inc_q <= phase_inc_d;
                                point_idx_q <= point_idx_q + IDX_W'(1);
                                state_q     <= ST_SETTLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.phase_inc  = phase_inc_q;
    assign bus.busy       = busy_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.point_idx  = point_idx_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the 32-bit phase-increment CORDIC NCO used in the VNA path.
- Drives the NCO phase increment through a programmed list of equally spaced points.
- At each point, waits for the CORDIC pipeline to flush, then opens a measurement window of programmable length.
- Reports the point index to the downstream accumulator/readout logic.

Parameters:
- PHASE_W, 32: width of the phase increment; matches the NCO.
- IDX_W, 16: width of the point count and index.
- DWELL_W, 16: width of the dwell count.
- SETTLE_CYC, 33: cycles from a phase_inc change until the NCO outputs reflect it (1 accumulator + 1 quadrant stage + 31 CORDIC stages). Must be ≥ 1.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  terminates any sweep.
- cfg_start_inc  in  PHASE_W  phase increment of point 0.
- cfg_step_inc  in  PHASE_W  increment added per point; unsigned, wraps mod 2^PHASE_W (negative steps via two's complement).
- cfg_num_points  in  IDX_W  number of points in the sweep.
- cfg_dwell  in  DWELL_W  measurement cycles per point; 0 is treated as 1.
- phase_inc  out  PHASE_W  to the NCO phase_inc input.
- busy  out  1  high in any state except IDLE.
- meas_valid  out  1  NCO output is settled at the current point.
- point_idx  out  IDX_W  index of the current point.
- done  out  1  one-cycle pulse when a sweep completes normally.
- aborted  out  1  one-cycle pulse when a sweep is terminated by abort.

Behaviour:
- Reset values: phase_inc=0, busy=0, meas_valid=0, point_idx=0, done=0, aborted=0, state=IDLE.
- All outputs are registered.
- States: IDLE, SETTLE, DWELL, DONE.
- Configuration is latched into shadow registers on an accepted start. cfg_* changes during a sweep have no effect.
- IDLE:
  - phase_inc holds its last value, so the NCO keeps running at the final frequency.
  - start with cfg_num_points=0: done pulses on the next cycle; the state stays IDLE; phase_inc is unchanged.
  - start with cfg_num_points>0, at edge E0: phase_inc←cfg_start_inc, point_idx←0, settle_cnt←SETTLE_CYC-1, go to SETTLE.
- SETTLE:
  - meas_valid=0; settle_cnt decrements each cycle.
  - At settle_cnt=0: dwell_cnt←max(dwell,1)-1, go to DWELL.
  - The first meas_valid is therefore high after edge E0+SETTLE_CYC.
- DWELL:
  - meas_valid=1 every cycle, for exactly max(dwell,1) cycles; dwell_cnt decrements.
  - At dwell_cnt=0 and point_idx=num_points-1: go to DONE.
  - At dwell_cnt=0 otherwise: phase_inc←phase_inc+step (mod 2^PHASE_W), point_idx+1, settle_cnt←SETTLE_CYC-1, go to SETTLE.
  - meas_valid falls on the same edge that changes phase_inc.
- DONE:
  - done=1 for one cycle, busy still 1.
  - Next state is IDLE; point_idx holds the last index.
- abort, in any non-IDLE state:
  - On the next edge: state←IDLE, meas_valid←0, aborted←1 for one cycle.
  - done is not asserted; phase_inc and point_idx hold.
  - abort in IDLE is ignored.
  - abort has priority over start in the same cycle.
- start while busy is ignored; it is not queued.
- Counter widths:
  - point_idx and the num_points compare use IDX_W. num_points=2^IDX_W-1 sweeps fully with no overflow.
  - The phase_inc addition truncates to PHASE_W bits.
- reset_n assertion mid-sweep: all registers return to reset values immediately (asynchronous); no done/aborted pulse.
- Reset deassertion is assumed synchronised externally.

Decomposition:
- Shared package nco_sweep_pkg:
  - state enum (IDLE, SETTLE, DWELL, DONE);
  - constant for the default SETTLE_CYC (33), shared with the NCO owner.
- One sub-module is natural: nco_sweep_timer.
  - Loadable down-counter with load value, load strobe and zero flag.
  - Instantiated twice: settle, width ceil(log2(SETTLE_CYC)); dwell, width DWELL_W.
- Everything else stays in the top FSM.

Test Plan:
- Basic sweep: start_inc=0x01000000, step=0x00100000, num=3, dwell=4 → phase_inc steps 0x01000000/0x01100000/0x01200000.
  - First meas_valid 33 cycles after start, 4 cycles each point, 33-cycle gaps.
  - point_idx 0,1,2; done pulse 1 cycle after the last dwell; busy falls the cycle after done.
- Wrap and negative step: start_inc=0xFFF00000, step=0x00200000, num=2 → point 1 phase_inc=0x00100000.
  - Step=0xFFF00000 from start_inc=0x00100000 gives phase_inc=0x00000000 at point 1.
- Edge configs:
  - num=0 → done pulse, busy never high, phase_inc unchanged.
  - dwell=0 → meas_valid exactly 1 cycle per point.
  - num=1 → single point then done.
- Abort:
  - abort during the 2nd SETTLE → aborted pulse, meas_valid stays 0, phase_inc holds the point-1 value, no done.
  - abort+start in the same IDLE cycle → sweep starts.
  - abort+start while busy → aborts.
- Config isolation: change all cfg_* and pulse start mid-sweep → the sweep continues with the original values.
- Reset mid-DWELL: drop reset_n asynchronously → all outputs 0 immediately.
  - After release, a new start performs a clean sweep.
- Checker: a bench model of the NCO pipeline confirms every meas_valid cycle sees a CORDIC output computed from the current phase_inc.
